// File: rtl/door_sequencer.sv
// door_sequencer
//   Turns a user button press into an open / hold / close cycle for the door
//   motor. Watches the limit switches and the obstruction sensor, enforces a
//   travel timeout, and latches a fault until it is explicitly cleared.
//
// Ports
//   clk           system clock, all state on rising edge
//   rst_n         asynchronous active-low reset
//   button        open request, level, synchronous to clk
//   limit_open    door fully open switch
//   limit_closed  door fully closed switch
//   obstruct      obstruction sensor
//   fault_clr     single-cycle fault acknowledge
//   motor_open    drive motor in open direction
//   motor_close   drive motor in close direction
//   door_open     door held fully open
//   fault         latched fault indicator
//   state_out     current state code (debug)
module door_sequencer #(
  parameter int HOLD_CYCLES = 100,
  parameter int TRAVEL_MAX  = 200,
  parameter int CNT_W       = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       button,
  input  logic       limit_open,
  input  logic       limit_closed,
  input  logic       obstruct,
  input  logic       fault_clr,
  output logic       motor_open,
  output logic       motor_close,
  output logic       door_open,
  output logic       fault,
  output logic [2:0] state_out
);

  localparam logic [2:0] S_CLOSED  = 3'd0;
  localparam logic [2:0] S_OPENING = 3'd1;
  localparam logic [2:0] S_OPEN    = 3'd2;
  localparam logic [2:0] S_CLOSING = 3'd3;
  localparam logic [2:0] S_FAULT   = 3'd4;

  // Last count value before the timed transition fires on the following edge.
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TRAVEL_LAST = CNT_W'(TRAVEL_MAX - 1);

  logic [2:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             button_d;
  logic             press;
  logic             hold_rst;
  logic             cnt_run;

  // Rising edge of the level button: a held button yields one press.
  assign press = button & ~button_d;

  assign cnt_run = (state == S_OPENING) || (state == S_OPEN) || (state == S_CLOSING);

  always_comb begin
    state_nxt = state;
    hold_rst  = 1'b0;
    case (state)
      S_CLOSED: begin
        if (press) state_nxt = S_OPENING;
      end
      S_OPENING: begin
        if (limit_open & limit_closed)  state_nxt = S_FAULT;
        else if (limit_open)            state_nxt = S_OPEN;
        else if (cnt == TRAVEL_LAST)    state_nxt = S_FAULT;
      end
      S_OPEN: begin
        // Obstruction or a fresh press restarts the hold window.
        if (obstruct | press)           hold_rst  = 1'b1;
        else if (cnt == HOLD_LAST)      state_nxt = S_CLOSING;
      end
      S_CLOSING: begin
        // Reversal is checked before limit_closed so an obstruction seen on
        // the same cycle the door lands still reopens it.
        if (limit_open & limit_closed)  state_nxt = S_FAULT;
        else if (obstruct | press)      state_nxt = S_OPENING;
        else if (limit_closed)          state_nxt = S_CLOSED;
        else if (cnt == TRAVEL_LAST)    state_nxt = S_FAULT;
      end
      S_FAULT: begin
        // Clearing a fault reopens the door rather than closing it.
        if (fault_clr) state_nxt = S_OPENING;
      end
      default: state_nxt = S_FAULT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_CLOSED;
      cnt      <= '0;
      button_d <= 1'b0;
    end else begin
      state    <= state_nxt;
      button_d <= button;
      if ((state_nxt != state) || hold_rst) cnt <= '0;
      else if (cnt_run && (cnt != '1))      cnt <= cnt + 1'b1;
    end
  end

  // Moore decode: outputs follow the state register only.
  assign motor_open  = (state == S_OPENING);
  assign motor_close = (state == S_CLOSING);
  assign door_open   = (state == S_OPEN);
  assign fault       = (state == S_FAULT);
  assign state_out   = state;

endmodule

// File: tb/tb_door_sequencer.sv
module tb_door_sequencer;

  localparam int HOLD = 4;
  localparam int TRAV = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       button, limit_open, limit_closed, obstruct, fault_clr;
  logic       motor_open, motor_close, door_open, fault;
  logic [2:0] state_out;

  door_sequencer #(.HOLD_CYCLES(HOLD), .TRAVEL_MAX(TRAV), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .button(button), .limit_open(limit_open),
    .limit_closed(limit_closed), .obstruct(obstruct), .fault_clr(fault_clr),
    .motor_open(motor_open), .motor_close(motor_close), .door_open(door_open),
    .fault(fault), .state_out(state_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       b, lo, lc, obs, clr;
    logic [2:0] exp;
  } vec_t;

  vec_t        vecs[$];
  logic [2:0]  sb[$];
  int          n_chk  = 0;
  int          n_fail = 0;

  task automatic chk(input string name, input int idx, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [%0d]: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic chk_outs(input int idx, input logic [2:0] e);
    chk("state_out",   idx, int'(state_out),   int'(e));
    chk("motor_open",  idx, int'(motor_open),  int'(e == 3'd1));
    chk("door_open",   idx, int'(door_open),   int'(e == 3'd2));
    chk("motor_close", idx, int'(motor_close), int'(e == 3'd3));
    chk("fault",       idx, int'(fault),       int'(e == 3'd4));
    chk("motor_excl",  idx, int'(motor_open & motor_close), 0);
  endtask

  function automatic void add(input logic b, lo, lc, obs, clr, input logic [2:0] e);
    vec_t v;
    v.b = b; v.lo = lo; v.lc = lc; v.obs = obs; v.clr = clr; v.exp = e;
    vecs.push_back(v);
  endfunction

  task automatic drive(input vec_t v);
    button = v.b; limit_open = v.lo; limit_closed = v.lc;
    obstruct = v.obs; fault_clr = v.clr;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    logic [2:0] e;
    // ---- vector table: b lo lc obs clr -> expected state after the edge ----
    // basic cycle: 3 cycles opening, 4 open, 2 closing
    add(1,0,0,0,0, 1); add(0,0,0,0,0, 1); add(0,0,0,0,0, 1);
    add(0,1,0,0,0, 2); add(0,1,0,0,0, 2); add(0,1,0,0,0, 2); add(0,1,0,0,0, 2);
    add(0,1,0,0,0, 3); add(0,0,0,0,0, 3); add(0,0,1,0,0, 0); add(0,0,1,0,0, 0);
    // button held 20 cycles: one OPENING entry only
    add(1,0,0,0,0, 1); add(1,0,0,0,0, 1); add(1,1,0,0,0, 2);
    add(1,1,0,0,0, 2); add(1,1,0,0,0, 2); add(1,1,0,0,0, 2);
    add(1,0,0,0,0, 3); add(1,0,0,0,0, 3); add(1,0,1,0,0, 0);
    for (int i = 0; i < 11; i++) add(1,0,1,0,0, 0);
    add(0,0,0,0,0, 0);
    // re-press while open restarts the hold window
    add(1,0,0,0,0, 1); add(0,0,0,0,0, 1); add(0,1,0,0,0, 2); add(0,1,0,0,0, 2);
    add(1,1,0,0,0, 2); add(0,1,0,0,0, 2); add(0,1,0,0,0, 2); add(0,1,0,0,0, 2);
    add(0,0,0,0,0, 3);
    // obstruct and limit_closed together while closing: reversal wins
    add(0,0,1,1,0, 1);
    // opening timeout: fault on the 8th edge after entry
    for (int i = 0; i < TRAV-1; i++) add(0,0,0,0,0, 1);
    add(0,0,0,0,0, 4);
    // fault ignores button, limits, obstruct; fault_clr reopens
    add(1,0,0,0,0, 4); add(0,0,0,0,0, 4); add(1,1,0,1,0, 4); add(0,0,0,0,0, 4);
    add(0,0,0,0,1, 1); add(0,0,0,0,0, 1);
    // sensor conflict while closing
    add(0,1,0,0,0, 2); add(0,0,0,0,0, 2); add(0,0,0,0,0, 2); add(0,0,0,0,0, 2);
    add(0,0,0,0,0, 3); add(0,1,1,0,0, 4);
    // sensor conflict while opening
    add(0,0,0,0,1, 1); add(0,1,1,0,0, 4);
    add(0,0,0,0,1, 1); add(0,0,0,0,0, 1);

    // ---- reset state ----
    rst_n = 1'b0;
    v.b = 0; v.lo = 0; v.lc = 0; v.obs = 0; v.clr = 0; v.exp = 0;
    drive(v);
    repeat (2) @(posedge clk);
    #1 chk_outs(-1, 3'd0);
    @(negedge clk) rst_n = 1'b1;

    // ---- apply table through the scoreboard ----
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i]);
      sb.push_back(vecs[i].exp);
      @(posedge clk);
      #1;
      if (sb.size() == 0) chk("sb_empty", i, 1, 0);
      else begin
        e = sb.pop_front();
        chk_outs(i, e);
      end
    end

    // ---- async reset in the middle of OPENING ----
    chk("pre_rst_motor", 900, int'(motor_open), 1);
    #2 rst_n = 1'b0;
    #1;
    chk_outs(901, 3'd0);
    @(negedge clk);
    limit_open = 1'b1;
    @(posedge clk);
    #1 chk_outs(902, 3'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1 chk_outs(903, 3'd0);
    @(negedge clk) begin limit_open = 1'b0; button = 1'b1; end
    @(posedge clk);
    #1 chk_outs(904, 3'd1);
    @(negedge clk) button = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/door_sequencer.md
Name: door_sequencer

Overview:
Sequences the door motor for the door actuator path. It turns a button press into an open / hold / close cycle. It watches the limit switches and the obstruction sensor, enforces a travel timeout, and latches a fault until it is explicitly cleared. It sits between the user button logic and the motor drivers.

Parameters:
HOLD_CYCLES, 100, cycles the door stays fully open before auto-close (>=2)
TRAVEL_MAX, 200, max cycles allowed in OPENING or CLOSING before fault (>=2)
CNT_W, 16, width of the shared hold/travel counter; must hold max(HOLD_CYCLES, TRAVEL_MAX)

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
button  input  1  open request, level; already synchronous to clk
limit_open  input  1  door fully open switch, active high
limit_closed  input  1  door fully closed switch, active high
obstruct  input  1  obstruction sensor, active high
fault_clr  input  1  single-cycle fault acknowledge
motor_open  output  1  drive motor in open direction
motor_close  output  1  drive motor in close direction
door_open  output  1  door held fully open
fault  output  1  latched fault indicator
state_out  output  3  current state code, for debug

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low; asserting it forces every register to its reset value immediately.
- Reset values:
  - state = CLOSED (code 0), cnt = 0, button_d = 0.
  - motor_open, motor_close, door_open and fault are all 0.
  - state_out = 3'd0.
- State codes: CLOSED=0, OPENING=1, OPEN=2, CLOSING=3, FAULT=4. Codes 5-7 are illegal and return to FAULT on the next edge.
- Press detect: press = button & ~button_d, with button_d registered every cycle. A held button gives exactly one press.
- Outputs are a pure decode of the state register (Moore). They change on the edge that changes state, so there is 1 cycle of latency from input to output.
  - motor_open = (state==OPENING)
  - motor_close = (state==CLOSING)
  - door_open = (state==OPEN)
  - fault = (state==FAULT)
  - motor_open and motor_close are never both 1.
- cnt clears to 0 on every state change. Otherwise it increments by 1 per cycle in OPENING, CLOSING and OPEN, and saturates (no wrap).
- Transitions, evaluated in the priority order listed within each state:
  - CLOSED:
    1. press -> OPENING.
    2. Otherwise stay. obstruct and the limit switches are ignored.
  - OPENING:
    1. limit_open & limit_closed -> FAULT (sensor conflict).
    2. limit_open -> OPEN.
    3. cnt==TRAVEL_MAX-1 -> FAULT.
    4. A press is ignored.
  - OPEN:
    1. obstruct or press -> cnt=0, stay (hold restarts).
    2. cnt==HOLD_CYCLES-1 -> CLOSING.
  - CLOSING:
    1. limit_open & limit_closed -> FAULT.
    2. obstruct or press -> OPENING (reversal wins over limit_closed in the same cycle).
    3. limit_closed -> CLOSED.
    4. cnt==TRAVEL_MAX-1 -> FAULT.
  - FAULT:
    1. fault_clr -> OPENING (fail-safe: door reopens).
    2. Otherwise stay. button, obstruct and the limits are ignored.
- Reset mid-motion: motors drop in the same cycle (asynchronous reset). After release the block is in CLOSED whatever the switch levels; the next press reopens the door.
- The timeout counts full cycles in the state. Entering OPENING at edge N with no limit switch gives FAULT at edge N+TRAVEL_MAX.

Test Plan:
- HOLD_CYCLES=4, TRAVEL_MAX=8, with reset released. Pulse button for 1 cycle, raise limit_open 3 cycles later, drop it on leaving OPEN, raise limit_closed 2 cycles into CLOSING -> motor_open=1 for 3 cycles, door_open=1 for 4 cycles, motor_close=1 for 2 cycles, then state_out=0.
- Hold button high for 20 cycles from CLOSED -> only one OPENING entry. Pressing again while in OPEN keeps door_open=1 for 4 cycles after the last press.
- In CLOSING, assert obstruct and limit_closed in the same cycle -> next state_out=1, motor_open=1, motor_close=0.
- In OPENING, with no limit switch for 8 cycles -> fault=1 and both motors 0. fault remains 1 through button presses. A fault_clr pulse -> state_out=1 on the next cycle.
- In CLOSING, raise limit_open and limit_closed together -> state_out=4 on the next cycle.
- Assert rst_n=0 asynchronously in the middle of OPENING -> motor_open falls before the next clk edge and all outputs are 0. After release with limit_open=1, state_out=0.
